// File: rtl/lbp_host.sv
// ---------------------------------------------------------------------------
// lbp_host
//
// Host-side memory and bookkeeping for a Local Binary Pattern engine.
//
// A loader fills the image memory while the host is IDLE. A pulse on
// img_load_done hands the image to the engine (SERVE). The engine reads
// pixels through a zero-latency combinational port. It writes LBP codes into
// the result memory. When finish is raised, the host moves to DONE. In DONE
// it reports whether the run produced exactly one code per interior pixel
// and no protocol or border errors occurred. A second img_load_done reruns
// the engine on the retained image.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   img_wr_en/addr/data loader write port (honoured in IDLE only)
//   img_load_done       one-cycle pulse: start serving (IDLE or DONE)
//   gray_req/addr       engine pixel read request
//   gray_ready          registered: host is serving
//   gray_data           combinational pixel at gray_addr (8'h00 if not served)
//   lbp_valid/addr/data engine result write port
//   finish              engine completion flag
//   rd_addr, rd_data    result readback, one cycle latency, any state
//   wr_count            accepted result writes, saturating
//   err_border          sticky: a result was written to a border pixel
//   err_proto           sticky: lbp_valid seen outside SERVE
//   done                in DONE state
//   result_ok           done, exact write count and no error flags
// ---------------------------------------------------------------------------
module lbp_host #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          img_wr_en,
    input  logic [AW-1:0] img_wr_addr,
    input  logic [7:0]    img_wr_data,
    input  logic          img_load_done,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic          gray_ready,
    output logic [7:0]    gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [7:0]    lbp_data,
    input  logic          finish,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] wr_count,
    output logic          err_border,
    output logic          err_proto,
    output logic          done,
    output logic          result_ok
);

    localparam int NPIX = IMG_W * IMG_H;

    // One extra bit so that NPIX == 2**AW is still representable.
    localparam logic [AW:0]   NPIX_X    = (AW+1)'(NPIX);
    localparam logic [AW-1:0] W_A       = AW'(IMG_W);
    localparam logic [AW-1:0] LAST_ROW  = AW'(IMG_H - 1);
    localparam logic [AW-1:0] LAST_COL  = AW'(IMG_W - 1);
    localparam logic [AW-1:0] EXP_COUNT = AW'((IMG_W - 2) * (IMG_H - 2));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          gray_ready_q, gray_ready_d;
    logic [AW-1:0] wr_count_q, wr_count_d;
    logic          err_border_q, err_border_d;
    logic          err_proto_q, err_proto_d;
    logic [7:0]    rd_data_q;

    // Memories are deliberately left out of reset so an image survives a
    // reset issued in the middle of a run.
    logic [7:0] image_mem  [0:NPIX-1];
    logic [7:0] result_mem [0:NPIX-1];

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NPIX_X;
    endfunction

    function automatic logic is_border(input logic [AW-1:0] a);
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        row = a / W_A;
        col = a % W_A;
        return in_range(a) &&
               (row == '0 || row == LAST_ROW || col == '0 || col == LAST_COL);
    endfunction

    logic load_start;
    logic lbp_accept;
    logic proto_viol;
    logic img_we;

    // A load pulse is only meaningful when not already serving.
    assign load_start = img_load_done && (state_q != SERVE);
    assign lbp_accept = lbp_valid && (state_q == SERVE);
    assign proto_viol = lbp_valid && (state_q != SERVE);
    // A write coinciding with img_load_done in IDLE still lands.
    assign img_we     = img_wr_en && (state_q == IDLE) && in_range(img_wr_addr);

    // ------------------------------------------------------------------
    // Next-state and bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_count_d   = wr_count_q;
        err_border_d = err_border_q;
        err_proto_d  = err_proto_q;

        unique case (state_q)
            IDLE:    if (img_load_done) state_d = SERVE;
            SERVE:   if (finish)        state_d = DONE;
            DONE:    if (img_load_done) state_d = SERVE;
            default: state_d = IDLE;
        endcase

        if (load_start) begin
            // Fresh run: counters restart, but a stray lbp_valid in the
            // very same cycle is still a protocol violation worth keeping.
            wr_count_d   = '0;
            err_border_d = 1'b0;
            err_proto_d  = proto_viol;
        end else begin
            if (lbp_accept) begin
                if (wr_count_q != '1) begin
                    wr_count_d = wr_count_q + 1'b1;
                end
                if (is_border(lbp_addr)) begin
                    err_border_d = 1'b1;
                end
            end
            if (proto_viol) begin
                err_proto_d = 1'b1;
            end
        end

        // Registered so the engine sees ready in the first SERVE cycle.
        gray_ready_d = (state_d == SERVE);
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            gray_ready_q <= 1'b0;
            wr_count_q   <= '0;
            err_border_q <= 1'b0;
            err_proto_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gray_ready_q <= gray_ready_d;
            wr_count_q   <= wr_count_d;
            err_border_q <= err_border_d;
            err_proto_q  <= err_proto_d;
        end
    end

    // ------------------------------------------------------------------
    // Image memory: loader writes, engine reads combinationally
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && img_we) begin
            image_mem[img_wr_addr] <= img_wr_data;
        end
    end

    always_comb begin
        gray_data = 8'h00;
        if ((state_q == SERVE) && gray_req && in_range(gray_addr)) begin
            gray_data = image_mem[gray_addr];
        end
    end

    // ------------------------------------------------------------------
    // Result memory: engine writes, registered readback
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && lbp_accept && in_range(lbp_addr)) begin
            result_mem[lbp_addr] <= lbp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= 8'h00;
        end else if (in_range(rd_addr)) begin
            rd_data_q <= result_mem[rd_addr];
        end else begin
            rd_data_q <= 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gray_ready = gray_ready_q;
    assign rd_data    = rd_data_q;
    assign wr_count   = wr_count_q;
    assign err_border = err_border_q;
    assign err_proto  = err_proto_q;
    assign done       = (state_q == DONE);
    assign result_ok  = done && (wr_count_q == EXP_COUNT) &&
                        !err_border_q && !err_proto_q;

endmodule

// File: tb/tb_lbp_host.sv
module tb_lbp_host;

    localparam int W    = 128;
    localparam int H    = 128;
    localparam int AW   = 14;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          img_wr_en;
    logic [AW-1:0] img_wr_addr;
    logic [7:0]    img_wr_data;
    logic          img_load_done;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic          gray_ready;
    logic [7:0]    gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW-1:0] wr_count;
    logic          err_border;
    logic          err_proto;
    logic          done;
    logic          result_ok;

    lbp_host #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .img_wr_en     (img_wr_en),
        .img_wr_addr   (img_wr_addr),
        .img_wr_data   (img_wr_data),
        .img_load_done (img_load_done),
        .gray_req      (gray_req),
        .gray_addr     (gray_addr),
        .gray_ready    (gray_ready),
        .gray_data     (gray_data),
        .lbp_valid     (lbp_valid),
        .lbp_addr      (lbp_addr),
        .lbp_data      (lbp_data),
        .finish        (finish),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_count      (wr_count),
        .err_border    (err_border),
        .err_proto     (err_proto),
        .done          (done),
        .result_ok     (result_ok)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] img    [0:NPIX-1];
    logic [7:0] golden [0:NPIX-1];

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic [7:0]    exp;
    } gvec_t;
    gvec_t gtab [6];

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    exp;
    } rb_t;
    rb_t sbq [$];

    function automatic logic [7:0] pix(input int i);
        if (i == 129) return 8'h50;
        return 8'((i * 29) ^ (i >> 5) ^ 8'h5A);
    endfunction

    // Reference LBP: neighbours clockwise from top-left, MSB first, bit set
    // when neighbour >= centre.
    function automatic logic [7:0] lbp_of(input int a);
        int off [8];
        logic [7:0] code;
        off = '{-W-1, -W, -W+1, 1, W+1, W, W-1, -1};
        code = 8'h00;
        for (int k = 0; k < 8; k++) begin
            code[7-k] = (img[a + off[k]] >= img[a]);
        end
        return code;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard readback: expectation queued when the address is driven,
    // popped once the registered data is available.
    task automatic rd_issue(input int a);
        rb_t e;
        rd_addr = AW'(a);
        sbq.push_back('{AW'(a), golden[a]});
        tick();
        e = sbq.pop_front();
        chk($sformatf("rd_data[%0d]", e.addr), 32'(rd_data), 32'(e.exp));
    endtask

    initial begin
        int gmis;
        int a;

        for (int i = 0; i < NPIX; i++) begin
            img[i]    = pix(i);
            golden[i] = 8'h00;
        end
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                golden[r*W + c] = lbp_of(r*W + c);

        gtab[0] = '{1'b1, AW'(129),   8'h50};
        gtab[1] = '{1'b0, AW'(129),   8'h00};
        gtab[2] = '{1'b1, AW'(0),     pix(0)};
        gtab[3] = '{1'b1, AW'(16383), pix(16383)};
        gtab[4] = '{1'b1, AW'(130),   pix(130)};
        gtab[5] = '{1'b1, AW'(8000),  pix(8000)};

        reset = 1'b1; img_wr_en = 1'b0; img_wr_addr = '0; img_wr_data = '0;
        img_load_done = 1'b0; gray_req = 1'b0; gray_addr = '0;
        lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0;
        rd_addr = '0;
        tick(); tick();

        // Reset state
        chk("rst gray_ready", 32'(gray_ready), 0);
        chk("rst rd_data",    32'(rd_data),    0);
        chk("rst wr_count",   32'(wr_count),   0);
        chk("rst err_border", 32'(err_border), 0);
        chk("rst err_proto",  32'(err_proto),  0);
        chk("rst done",       32'(done),       0);
        reset = 1'b0;
        tick();

        // IDLE: reads return zero
        gray_req = 1'b1; gray_addr = AW'(129); #1;
        chk("idle gray_data", 32'(gray_data), 0);
        gray_req = 1'b0;

        // Load image; final write coincides with img_load_done
        for (int i = 0; i < NPIX; i++) begin
            img_wr_en = 1'b1; img_wr_addr = AW'(i); img_wr_data = img[i];
            img_load_done = (i == NPIX - 1);
            tick();
        end
        img_wr_en = 1'b0; img_load_done = 1'b0;
        chk("serve gray_ready", 32'(gray_ready), 1);
        chk("serve wr_count",   32'(wr_count),   0);

        // Table-driven combinational read vectors
        for (int t = 0; t < 6; t++) begin
            gray_req = gtab[t].req; gray_addr = gtab[t].addr; #1;
            chk($sformatf("gray_data vec%0d", t), 32'(gray_data), 32'(gtab[t].exp));
        end

        // Reference engine over interior pixels
        gmis = 0;
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                a = r*W + c;
                gray_req = 1'b1; gray_addr = AW'(a);
                lbp_valid = 1'b1; lbp_addr = AW'(a); lbp_data = golden[a];
                #1;
                if (gray_data !== img[a]) gmis++;
                tick();
            end
        end
        lbp_valid = 1'b0; gray_req = 1'b0;
        chk("engine gray mismatches", 32'(gmis), 0);
        finish = 1'b1; tick(); finish = 1'b0;
        chk("run done",       32'(done),       1);
        chk("run wr_count",   32'(wr_count),   15876);
        chk("run err_border", 32'(err_border), 0);
        chk("run err_proto",  32'(err_proto),  0);
        chk("run result_ok",  32'(result_ok),  1);
        chk("run gray_ready", 32'(gray_ready), 0);
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                rd_issue(r*W + c);

        // DONE: loader write ignored, then rerun
        img_wr_en = 1'b1; img_wr_addr = AW'(129); img_wr_data = 8'hAA;
        tick(); img_wr_en = 1'b0;
        chk("done hold", 32'(done), 1);
        img_load_done = 1'b1; tick(); img_load_done = 1'b0;
        chk("rerun gray_ready", 32'(gray_ready), 1);
        chk("rerun wr_count",   32'(wr_count),   0);
        chk("rerun done",       32'(done),       0);
        chk("rerun result_ok",  32'(result_ok),  0);
        gray_req = 1'b1; gray_addr = AW'(129); #1;
        chk("retained pix129", 32'(gray_data), 32'h50);
        gray_req = 1'b0;

        // Same-cycle write and finish
        lbp_valid = 1'b1; lbp_addr = AW'(16126); lbp_data = 8'h3C; finish = 1'b1;
        tick(); lbp_valid = 1'b0; finish = 1'b0;
        chk("wf done",       32'(done),       1);
        chk("wf gray_ready", 32'(gray_ready), 0);
        chk("wf wr_count",   32'(wr_count),   1);
        chk("wf result_ok",  32'(result_ok),  0);
        golden[16126] = 8'h3C;
        rd_issue(16126);

        // Border write
        img_load_done = 1'b1; tick(); img_load_done = 1'b0;
        lbp_valid = 1'b1; lbp_addr = AW'(0); lbp_data = 8'hFF;
        tick(); lbp_valid = 1'b0;
        chk("border err_border", 32'(err_border), 1);
        chk("border wr_count",   32'(wr_count),   1);
        finish = 1'b1; tick(); finish = 1'b0;
        chk("border done",      32'(done),      1);
        chk("border result_ok", 32'(result_ok), 0);
        golden[0] = 8'hFF;
        rd_issue(0);

        // lbp_valid in DONE
        lbp_valid = 1'b1; lbp_addr = AW'(300); lbp_data = 8'h99;
        tick(); lbp_valid = 1'b0;
        chk("done err_proto", 32'(err_proto), 1);
        chk("done wr_count",  32'(wr_count),  1);
        rd_issue(300);

        // Rerun, then reset mid-SERVE with competing inputs
        img_load_done = 1'b1; tick(); img_load_done = 1'b0;
        chk("clr err_proto",  32'(err_proto),  0);
        chk("clr err_border", 32'(err_border), 0);
        lbp_valid = 1'b1; lbp_addr = AW'(1000); lbp_data = golden[1000];
        tick();
        reset = 1'b1; lbp_addr = AW'(2000); lbp_data = 8'hEE;
        img_load_done = 1'b1; finish = 1'b1;
        img_wr_en = 1'b1; img_wr_addr = AW'(129); img_wr_data = 8'h01;
        tick();
        reset = 1'b0; lbp_valid = 1'b0; img_load_done = 1'b0; finish = 1'b0;
        img_wr_en = 1'b0;
        chk("mrst gray_ready", 32'(gray_ready), 0);
        chk("mrst wr_count",   32'(wr_count),   0);
        chk("mrst err_border", 32'(err_border), 0);
        chk("mrst err_proto",  32'(err_proto),  0);
        chk("mrst done",       32'(done),       0);
        chk("mrst rd_data",    32'(rd_data),    0);
        rd_issue(2000);

        // finish in IDLE ignored
        finish = 1'b1; tick(); finish = 1'b0;
        chk("idle finish done", 32'(done), 0);

        // lbp_valid in IDLE
        lbp_valid = 1'b1; lbp_addr = AW'(200); lbp_data = 8'h11;
        tick(); lbp_valid = 1'b0;
        chk("idle err_proto", 32'(err_proto), 1);
        chk("idle wr_count",  32'(wr_count),  0);
        rd_issue(200);

        // Image survives reset
        img_load_done = 1'b1; tick(); img_load_done = 1'b0;
        chk("post-rst err_proto",  32'(err_proto),  0);
        chk("post-rst gray_ready", 32'(gray_ready), 1);
        gray_req = 1'b1; gray_addr = AW'(129); #1;
        chk("post-rst pix129", 32'(gray_data), 32'h50);
        gray_req = 1'b0;

        // Counter saturation
        lbp_valid = 1'b1; lbp_addr = AW'(1000); lbp_data = golden[1000];
        for (int i = 0; i < 16385; i++) tick();
        lbp_valid = 1'b0;
        chk("sat wr_count",   32'(wr_count),   32'h3FFF);
        chk("sat err_border", 32'(err_border), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lbp_host.md
LBP_HOST -- requirements
Module: lbp_host

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels.
REQ-002 Parameter IMG_H, default 128, image height in pixels.
REQ-003 Parameter AW, default 14, address width; IMG_W*IMG_H SHALL be <= 2**AW.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 img_wr_en  input  1  image memory write strobe (loader side).
REQ-007 img_wr_addr  input  AW  image memory write address.
REQ-008 img_wr_data  input  8  gray pixel to store.
REQ-009 img_load_done  input  1  one-cycle pulse; image loaded, start serving.
REQ-010 gray_req  input  1  engine read request.
REQ-011 gray_addr  input  AW  engine read address.
REQ-012 gray_ready  output  1  host ready; engine may run.
REQ-013 gray_data  output  8  pixel at gray_addr.
REQ-014 lbp_valid  input  1  engine result write strobe.
REQ-015 lbp_addr  input  AW  result address.
REQ-016 lbp_data  input  8  LBP code.
REQ-017 finish  input  1  engine completion flag.
REQ-018 rd_addr  input  AW  result memory readback address.
REQ-019 rd_data  output  8  registered result readback.
REQ-020 wr_count  output  AW  accepted result writes, saturating.
REQ-021 err_border  output  1  sticky: write to border pixel seen.
REQ-022 err_proto  output  1  sticky: lbp_valid outside SERVE seen.
REQ-023 done  output  1  finish observed.
REQ-024 result_ok  output  1  done and wr_count==(IMG_W-2)*(IMG_H-2) and no error flags.

Function
REQ-025 States IDLE, SERVE, DONE; encoded in a state register.
REQ-026 IDLE: gray_ready=0; img_wr_en=1 writes img_wr_data to image memory at img_wr_addr.
REQ-027 IDLE -> SERVE on img_load_done=1; wr_count, err_border, err_proto cleared in the same edge.
REQ-028 SERVE: gray_ready=1 registered, asserted first cycle after the transition edge; img_wr_en ignored.
REQ-029 gray_data SHALL be combinational: image_mem[gray_addr] when gray_req=1 and state SERVE, else 8'h00 (zero-latency read; engine samples on next edge).
REQ-030 gray_addr >= IMG_W*IMG_H with gray_req=1 SHALL return 8'h00.
REQ-031 SERVE, lbp_valid=1: result memory[lbp_addr] <= lbp_data; wr_count += 1, saturating at 2**AW-1.
REQ-032 Border = row 0, row IMG_H-1, col 0 or col IMG_W-1 (row = addr/IMG_W, col = addr%IMG_W); a SERVE write there still stores and SHALL set err_border.
REQ-033 lbp_valid=1 in IDLE or DONE SHALL not write memory, not count, and SHALL set err_proto.
REQ-034 SERVE -> DONE on finish=1; a lbp_valid in the same cycle is accepted first.
REQ-035 DONE: gray_ready=0, done=1; result_ok evaluated combinationally from registered counters/flags.
REQ-036 DONE -> SERVE on img_load_done=1 (rerun, image retained, counters/flags cleared); img_wr_en in DONE ignored.
REQ-037 finish in IDLE ignored.
REQ-038 rd_data <= result_mem[rd_addr] every cycle, any state (1-cycle latency); out-of-range address returns 8'h00.
REQ-039 Simultaneous img_wr_en and img_load_done in IDLE: write performed, then SERVE.

Reset
REQ-040 reset=1 at a clock edge: state IDLE, gray_ready=0, rd_data=0, wr_count=0, err_border=0, err_proto=0, done=0, regardless of current state.
REQ-041 Image and result memories SHALL NOT be cleared by reset; contents survive reset mid-SERVE.
REQ-042 reset dominates all other inputs in the same cycle.

Verification
REQ-043 Load addr 129 = 8'h50, pulse img_load_done, gray_req=1 gray_addr=129 -> gray_ready=1 next cycle, gray_data=8'h50 same cycle.
REQ-044 Full run: load 128x128 image, drive reference engine to finish -> done=1, wr_count=15876, err_border=0, result_ok=1, readback matches golden LBP.
REQ-045 SERVE write lbp_addr=0 data 8'hFF -> err_border=1, wr_count=1, rd_data at addr 0 = 8'hFF, result_ok=0 after finish.
REQ-046 lbp_valid=1 in IDLE at addr 200 -> err_proto=1, wr_count=0, result memory at 200 unchanged.
REQ-047 Same-cycle lbp_valid (addr 16126, 8'h3C) and finish -> write stored, wr_count increments, state DONE, gray_ready=0 next cycle.
REQ-048 reset mid-SERVE -> gray_ready=0, counters 0, state IDLE; image data at addr 129 still 8'h50 after next img_load_done.
